// File: rtl/mem_link_initiator.sv
// Host-side initiator for the byte-serial memory debug link.
// Serializes word write / read-burst commands into UART byte frames and
// reassembles read responses into 32-bit words.
// Optional build macro: MEM_LINK_TIMEOUT_EN enables the response stall timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command; cmd_ready high unless an error pulses
// LOAD    | frame built into the shift register, byte counter loaded
// SEND    | tx_start pulse for the byte at the bottom of the shift reg
// WAIT_HI | waiting for the UART to report busy
// WAIT_LO | waiting for the UART to finish the byte
// RECV    | collecting response bytes into words
module mem_link_initiator #(
    parameter int ADDR_WIDTH     = 13,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_end,
    input  logic [3:0]            cmd_we,
    input  logic [31:0]           cmd_wdata,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  err_range,
    output logic                  err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO, S_RECV
    } state_t;

    state_t state, state_nx;

    logic                  accept;
    logic                  range_bad;
    logic                  op_write;
    logic [15:0]           lat_addr;
    logic [15:0]           lat_end;
    logic [3:0]            lat_we;
    logic [31:0]           lat_wdata;
    logic [63:0]           shreg;
    logic [3:0]            byte_cnt;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [1:0]            rx_idx;
    logic [31:0]           rx_word;
    logic                  rx_take;
    logic                  word_done;
    logic                  byte_done;
    logic                  timeout_hit;

    assign accept    = cmd_valid && cmd_ready;
    assign range_bad = !cmd_write && (cmd_addr_end <= cmd_addr);
    assign byte_done = (state == S_WAIT_LO) && !tx_busy;
    // A zero word count marks the rd_last cycle; bytes arriving then are ignored.
    assign rx_take   = (state == S_RECV) && (word_cnt != '0) && rx_valid;
    assign word_done = rx_take && (rx_idx == 2'd3);
    assign tx_data   = shreg[7:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (accept && !range_bad) state_nx = S_LOAD;
            // Hold off the first byte if the UART is still draining an abandoned one.
            S_LOAD:    if (!tx_busy) state_nx = S_SEND;
            S_SEND:    state_nx = S_WAIT_HI;
            S_WAIT_HI: if (tx_busy) state_nx = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    if (byte_cnt > 4'd1) state_nx = S_SEND;
                    else if (op_write)   state_nx = S_IDLE;
                    else                 state_nx = S_RECV;
                end
            end
            S_RECV:    if (word_cnt == '0 || timeout_hit) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Decoded outputs; cmd_ready is withheld while an error pulse is showing.
    always_comb begin
        tx_start  = (state == S_SEND);
        busy      = (state != S_IDLE);
        cmd_ready = (state == S_IDLE) && !err_range && !err_timeout;
    end

    // Command fields captured at accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_write  <= 1'b0;
            lat_addr  <= '0;
            lat_end   <= '0;
            lat_we    <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            op_write  <= cmd_write;
            lat_addr  <= 16'(cmd_addr);
            lat_end   <= 16'(cmd_addr_end);
            lat_we    <= cmd_we;
            lat_wdata <= cmd_wdata;
        end
    end

    // Frame shift register: byte 0 sits in [7:0], zeros fill from the top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (state == S_LOAD) begin
            if (op_write) begin
                shreg    <= {lat_wdata[31:24], lat_wdata[23:16], lat_wdata[15:8],
                             lat_wdata[7:0], {4'b0000, lat_we}, lat_addr[15:8],
                             lat_addr[7:0], 8'h0F};
                byte_cnt <= 4'd8;
            end else begin
                shreg    <= {24'h000000, lat_end[15:8], lat_end[7:0],
                             lat_addr[15:8], lat_addr[7:0], 8'hFF};
                byte_cnt <= 4'd5;
            end
        end else if (byte_done) begin
            shreg    <= {8'h00, shreg[63:8]};
            byte_cnt <= byte_cnt - 4'd1;
        end
    end

    // Response assembly: bytes enter at the top, so the first byte ends up LSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt <= '0;
            rx_idx   <= '0;
            rx_word  <= '0;
            rd_data  <= '0;
        end else begin
            if (accept) word_cnt <= cmd_addr_end - cmd_addr;
            if (rx_take) begin
                rx_word <= {rx_data, rx_word[31:8]};
                rx_idx  <= rx_idx + 2'd1;
                if (rx_idx == 2'd3) begin
                    rd_data  <= {rx_data, rx_word[31:8]};
                    word_cnt <= word_cnt - ADDR_WIDTH'(1);
                end
            end else if (state != S_RECV) begin
                rx_idx  <= '0;
                rx_word <= '0;
            end
        end
    end

    // Registered word strobes and range-error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            err_range <= 1'b0;
        end else begin
            rd_valid  <= word_done;
            rd_last   <= word_done && (word_cnt == ADDR_WIDTH'(1));
            err_range <= accept && range_bad;
        end
    end

`ifdef MEM_LINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] stall_cnt;

    assign timeout_hit = (state == S_RECV) && (word_cnt != '0) && !rx_valid &&
                         (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter between response bytes; restarts on every byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (state != S_RECV || rx_valid) stall_cnt <= '0;
            else                             stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;

    // Without the timeout a stalled response simply waits for more bytes.
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

endmodule
